// File: rtl/ps2_scan_code_receiver.sv
// PS/2 keyboard scan-code receiver.
//
// Synchronizes and de-glitches kb_clk/kb_data. It decodes one 11-bit frame
// (start, 8 data bits LSB-first, odd parity, stop) per byte. It keeps the last
// four accepted codes packed into a 32-bit word for the display controller.
//
// Optional feature: define PS2_BREAK_FILTER_EN to drop break sequences. With it
// defined, F0 arms a break, E0 is ignored, and the byte after F0 is dropped.
// Without it, every valid byte is pushed.
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   kb_clk       PS/2 clock from keyboard (asynchronous)
//   kb_data      PS/2 data from keyboard (asynchronous)
//   scan_codes   last four accepted codes, newest in [7:0], oldest in [31:24]
//   scan_valid   one-cycle pulse when scan_codes updates
//   frame_error  one-cycle pulse on parity, stop or timeout error
module ps2_scan_code_receiver #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        kb_clk,
  input  logic        kb_data,
  output logic [31:0] scan_codes,
  output logic        scan_valid,
  output logic        frame_error
);

  localparam int unsigned FiltW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TmoW  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
  logic                   clk_s, data_s;
  logic                   filt_q, filt_d;
  logic [FiltW-1:0]       fcnt_q, fcnt_d;
  logic                   fall;

  state_e                 state_q, state_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   parity_q, parity_d;
  logic [TmoW-1:0]        tmo_q, tmo_d;
  logic                   tmo_hit;
  logic                   frame_ok;
  logic [31:0]            codes_q, codes_d;
  logic                   valid_q, valid_d;
  logic                   error_q, error_d;
`ifdef PS2_BREAK_FILTER_EN
  logic                   brk_q, brk_d;
`endif

  assign clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];

  // Glitch filter: filt follows clk_s only after FILTER_LEN consecutive disagreeing samples.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_s != filt_q) begin
      if (fcnt_q == FiltW'(FILTER_LEN - 1)) begin
        filt_d = clk_s;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  assign fall = filt_q & ~filt_d;

  assign tmo_hit = (state_q != StIdle) && !fall && (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));

  // Odd parity over data plus parity bit, and the stop bit must be high.
  assign frame_ok = data_s & (^{shift_q, parity_q});

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    codes_d   = codes_q;
    valid_d   = 1'b0;
    error_d   = 1'b0;
`ifdef PS2_BREAK_FILTER_EN
    brk_d     = brk_q;
`endif

    if (state_q == StIdle || fall || tmo_hit) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (fall && !data_s) begin
          state_d   = StData;
          bit_cnt_d = '0;
        end
      end
      StData: begin
        if (fall) begin
          shift_d   = {data_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = StParity;
        end
      end
      StParity: begin
        if (fall) begin
          parity_d = data_s;
          state_d  = StStop;
        end
      end
      StStop: begin
        if (fall) begin
          state_d = StIdle;
          if (!frame_ok) begin
            error_d = 1'b1;
          end else begin
`ifdef PS2_BREAK_FILTER_EN
            if (shift_q == 8'hF0) begin
              brk_d = 1'b1;
            end else if (shift_q == 8'hE0) begin
              // Extended prefix carries no key information.
            end else if (brk_q) begin
              brk_d = 1'b0;
            end else begin
              codes_d = {codes_q[23:0], shift_q};
              valid_d = 1'b1;
            end
`else
            codes_d = {codes_q[23:0], shift_q};
            valid_d = 1'b1;
`endif
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Keyboard went silent mid-frame: drop the partial byte.
    if (tmo_hit) begin
      state_d = StIdle;
      error_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      filt_q      <= 1'b1;
      fcnt_q      <= '0;
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      tmo_q       <= '0;
      codes_q     <= '0;
      valid_q     <= 1'b0;
      error_q     <= 1'b0;
`ifdef PS2_BREAK_FILTER_EN
      brk_q       <= 1'b0;
`endif
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], kb_clk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], kb_data};
      filt_q      <= filt_d;
      fcnt_q      <= fcnt_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      tmo_q       <= tmo_d;
      codes_q     <= codes_d;
      valid_q     <= valid_d;
      error_q     <= error_d;
`ifdef PS2_BREAK_FILTER_EN
      brk_q       <= brk_d;
`endif
    end
  end

  assign scan_codes  = codes_q;
  assign scan_valid  = valid_q;
  assign frame_error = error_q;

endmodule
